run_length_detector: RTL and testbench

//   Parametrised serial run-length detector. Watches a 1-bit stream and flags

---
 rtl/run_length_detector.sv | 151 +++++++++++++++
 tb/tb_run_length_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - serial run-length detector with zero/one thresholds
//
// Watches a qualified 1-bit stream and flags when the current run of identical
// bits reaches a programmable length. Zero runs and one runs have separate
// thresholds; a threshold of 0 disables detection for that bit value.
//
// Optional feature macro: RUNDET_HITCNT_EN (enables the saturating hit counter).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   en        in   sample qualifier; x is consumed only when en=1
//   x         in   serial input bit
//   mode      in   0 = level detect, 1 = one pulse per run
//   zero_len  in   zero-run threshold (0 disables)
//   one_len   in   one-run threshold (0 disables)
//   z         out  z_zero | z_one
//   z_zero    out  registered zero-run detect
//   z_one     out  registered one-run detect
//   run_len   out  length of the current run, saturating
//   clr_hits  in   synchronous clear of hit_cnt
//   hit_cnt   out  count of z rising events, saturating (0 without the macro)
module run_length_detector #(
    parameter int CNT_W = 4,
    parameter int HIT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             mode,
    input  logic [CNT_W-1:0] zero_len,
    input  logic [CNT_W-1:0] one_len,
    output logic             z,
    output logic             z_zero,
    output logic             z_one,
    output logic [CNT_W-1:0] run_len,
    input  logic             clr_hits,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             fired_q, fired_d;
    logic             z_zero_q, z_zero_d;
    logic             z_one_q, z_one_d;

    // Working values for the sampled bit.
    logic             same_run;
    logic             fired_run;
    logic [CNT_W-1:0] thr;
    logic             reached;
    logic             det;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            fired_q   <= 1'b0;
            z_zero_q  <= 1'b0;
            z_one_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            fired_q   <= fired_d;
            z_zero_q  <= z_zero_d;
            z_one_q   <= z_one_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        fired_d   = fired_q;
        z_zero_d  = 1'b0;
        z_one_d   = 1'b0;
        same_run  = (state_q == RUN0 && !x) || (state_q == RUN1 && x);
        fired_run = fired_q;
        thr       = x ? one_len : zero_len;
        reached   = 1'b0;
        det       = 1'b0;

        if (en) begin
            if (same_run) begin
                if (run_len_q != RUN_MAX) begin
                    run_len_d = run_len_q + 1'b1;
                end
            end else begin
                // New run (or first bit after IDLE): the pulse latch rearms.
                state_d   = x ? RUN1 : RUN0;
                run_len_d = {{(CNT_W-1){1'b0}}, 1'b1};
                fired_run = 1'b0;
            end

            // Threshold is compared against the updated length, so the
            // detect lands on the edge that consumes the qualifying bit.
            reached  = (thr != '0) && (run_len_d >= thr);
            det      = mode ? (reached && !fired_run) : reached;
            fired_d  = fired_run | (mode & det);
            z_one_d  = det & x;
            z_zero_d = det & ~x;
        end
    end

    assign z_zero  = z_zero_q;
    assign z_one   = z_one_q;
    assign z       = z_zero_q | z_one_q;
    assign run_len = run_len_q;

`ifdef RUNDET_HITCNT_EN
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             z_rise;

    // Counted on the same edge at which z rises.
    assign z_rise = (z_zero_d | z_one_d) & ~z;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (clr_hits) begin
            hit_cnt_d = '0;
        end else if (z_rise && hit_cnt_q != HIT_MAX) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    logic unused_clr_hits;
    assign unused_clr_hits = clr_hits;
    assign hit_cnt         = '0;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// tb/tb_run_length_detector.sv - self-checking bench for run_length_detector
module tb_run_length_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] zero_len = 4'd0;
    logic [3:0] one_len = 4'd0;
    logic       clr_hits = 1'b0;
    logic       z, z_zero, z_one;
    logic [3:0] run_len;
    logic [7:0] hit_cnt;

    int passed = 0;
    int total  = 0;

`ifdef RUNDET_HITCNT_EN
    int hit_on = 1;
`else
    int hit_on = 0;
`endif

    run_length_detector #(.CNT_W(4), .HIT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .x        (x),
        .mode     (mode),
        .zero_len (zero_len),
        .one_len  (one_len),
        .z        (z),
        .z_zero   (z_zero),
        .z_one    (z_one),
        .run_len  (run_len),
        .clr_hits (clr_hits),
        .hit_cnt  (hit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: last bit value (-1 = nothing sampled), run length,
    // pulse latch and expected outputs.
    int m_last = -1;
    int m_n = 0;
    int m_fired = 0;
    int m_zz = 0;
    int m_zo = 0;
    int m_hits = 0;

    task automatic model(input int r, input int e, input int b, input int md,
                         input int zl, input int ol, input int clr);
        int t;
        int det;
        int zprev;
        zprev = m_zz | m_zo;
        if (r != 0) begin
            m_last = -1; m_n = 0; m_fired = 0; m_zz = 0; m_zo = 0; m_hits = 0;
            return;
        end
        m_zz = 0;
        m_zo = 0;
        if (e != 0) begin
            if (m_last == b) begin
                m_n = (m_n + 1 > 15) ? 15 : m_n + 1;
            end else begin
                m_last = b; m_n = 1; m_fired = 0;
            end
            t = (b != 0) ? ol : zl;
            det = (t != 0 && m_n >= t) ? 1 : 0;
            if (md != 0) begin
                if (m_fired != 0) det = 0;
                if (det != 0) m_fired = 1;
            end
            if (b != 0) m_zo = det; else m_zz = det;
        end
        if (hit_on != 0) begin
            if (clr != 0) m_hits = 0;
            else if ((m_zz | m_zo) != 0 && zprev == 0 && m_hits < 255) m_hits++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic md,
                        input logic [3:0] zl, input logic [3:0] ol, input logic clr);
        rst = r; en = e; x = b; mode = md; zero_len = zl; one_len = ol; clr_hits = clr;
        model(int'(r), int'(e), int'(b), int'(md), int'(zl), int'(ol), int'(clr));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, en, x, mode;
        logic [3:0] zl, ol;
        logic       ezz, ezo;
        logic [3:0] erl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic b, input logic md,
                       input logic [3:0] zl, input logic [3:0] ol,
                       input logic ezz, input logic ezo, input logic [3:0] erl);
        vec_t v;
        v.rst = r; v.en = e; v.x = b; v.mode = md; v.zl = zl; v.ol = ol;
        v.ezz = ezz; v.ezo = ezo; v.erl = erl;
        tbl.push_back(v);
    endtask

    initial begin
        int npulse;
        logic pb;
        logic [3:0] rzl, rol;
        logic rmd;

        // Zero run with level detect, then a run change.
        add(1, 0, 0, 0, 3, 4, 0, 0, 0);
        add(0, 1, 0, 0, 3, 4, 0, 0, 1);
        add(0, 1, 0, 0, 3, 4, 0, 0, 2);
        add(0, 1, 0, 0, 3, 4, 1, 0, 3);
        add(0, 1, 0, 0, 3, 4, 1, 0, 4);
        add(0, 1, 1, 0, 3, 4, 0, 0, 1);
        // One run of five bits, threshold 4.
        add(1, 0, 0, 0, 3, 4, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 3, 4, 0, (i >= 4), 4'(i));
        // Gap in the qualifier holds the run; detect resumes.
        add(1, 0, 0, 0, 3, 4, 0, 0, 0);
        add(0, 1, 0, 0, 3, 4, 0, 0, 1);
        add(0, 1, 0, 0, 3, 4, 0, 0, 2);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3, 4, 0, 0, 2);
        add(0, 1, 0, 0, 3, 4, 1, 0, 3);
        add(0, 0, 0, 0, 3, 4, 0, 0, 3);
        // Disabled thresholds, then threshold 1 fires on the first bit of a run.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 4'(i));
        add(0, 1, 1, 0, 0, 1, 0, 1, 1);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].mode, tbl[i].zl, tbl[i].ol, 1'b0);
            check($sformatf("tbl%0d_z_zero", i), int'(z_zero), int'(tbl[i].ezz));
            check($sformatf("tbl%0d_z_one", i), int'(z_one), int'(tbl[i].ezo));
            check($sformatf("tbl%0d_z", i), int'(z), int'(tbl[i].ezz | tbl[i].ezo));
            check($sformatf("tbl%0d_run_len", i), int'(run_len), int'(tbl[i].erl));
        end

        // Pulse mode: one pulse per run.
        step(1, 0, 0, 1, 2, 0, 0);
        npulse = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 1, 2, 0, 0);
            check($sformatf("pulse_a%0d", i), int'(z), (i == 2) ? 1 : 0);
            npulse += int'(z);
        end
        step(0, 1, 1, 1, 2, 0, 0);
        check("pulse_b", int'(z), 0);
        npulse += int'(z);
        for (int i = 1; i <= 2; i++) begin
            step(0, 1, 0, 1, 2, 0, 0);
            check($sformatf("pulse_c%0d", i), int'(z_zero), (i == 2) ? 1 : 0);
            npulse += int'(z);
        end
        check("pulse_count", npulse, 2);

        // Saturation at 15 with threshold 15.
        step(1, 0, 0, 0, 0, 15, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 1, 0, 0, 15, 0);
            check($sformatf("sat_run_len%0d", i), int'(run_len), (i > 15) ? 15 : i);
            check($sformatf("sat_z_one%0d", i), int'(z_one), (i >= 15) ? 1 : 0);
            check($sformatf("sat_z_zero%0d", i), int'(z_zero), 0);
        end

        // Hit counter over three qualifying runs, then reset mid-run, then clear.
        step(1, 0, 0, 1, 2, 0, 0);
        for (int r = 0; r < 3; r++) begin
            step(0, 1, 0, 1, 2, 0, 0);
            step(0, 1, 0, 1, 2, 0, 0);
            step(0, 1, 1, 1, 2, 0, 0);
        end
        check("hits_three", int'(hit_cnt), 3 * hit_on);
        step(0, 1, 0, 1, 2, 0, 0);
        step(1, 1, 0, 1, 2, 0, 0);
        check("rst_z", int'(z), 0);
        check("rst_z_zero", int'(z_zero), 0);
        check("rst_z_one", int'(z_one), 0);
        check("rst_run_len", int'(run_len), 0);
        check("rst_hit_cnt", int'(hit_cnt), 0);
        step(0, 1, 1, 1, 2, 0, 1);
        check("idle_restart_len", int'(run_len), 1);
        step(0, 1, 0, 1, 2, 0, 1);
        step(0, 1, 0, 1, 2, 0, 1);
        check("clr_pulse_seen", int'(z_zero), 1);
        check("clr_holds_zero", int'(hit_cnt), 0);

        // Randomised run against the model.
        pb = 1'b0; rmd = 1'b0; rzl = 4'd3; rol = 4'd2;
        for (int i = 0; i < 500; i++) begin
            logic r, e, c;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            if ($urandom_range(0, 99) < 4) rmd = ~rmd;
            if ($urandom_range(0, 99) < 6) rzl = 4'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 6) rol = 4'($urandom_range(0, 6));
            step(r, e, pb, rmd, rzl, rol, c);
            check($sformatf("rnd%0d_z_zero", i), int'(z_zero), m_zz);
            check($sformatf("rnd%0d_z_one", i), int'(z_one), m_zo);
            check($sformatf("rnd%0d_z", i), int'(z), m_zz | m_zo);
            check($sformatf("rnd%0d_run_len", i), int'(run_len), m_n);
            check($sformatf("rnd%0d_hit_cnt", i), int'(hit_cnt), m_hits);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
